// File: rtl/vga_timing_pkg.sv
// Mode constants and axis geometry helper shared by the VGA timing generator.
package vga_timing_pkg;

   typedef struct packed {
      int total;
      int width;
   } axis_dim_t;

   // 640x480@60
   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;
   localparam int VGA640_H_POL    = 0;
   localparam int VGA640_V_POL    = 0;

   // 800x600@72
   localparam int SVGA800_H_ACTIVE = 800;
   localparam int SVGA800_H_FP     = 56;
   localparam int SVGA800_H_SYNC   = 120;
   localparam int SVGA800_H_BP     = 64;
   localparam int SVGA800_V_ACTIVE = 600;
   localparam int SVGA800_V_FP     = 37;
   localparam int SVGA800_V_SYNC   = 6;
   localparam int SVGA800_V_BP     = 23;
   localparam int SVGA800_H_POL    = 1;
   localparam int SVGA800_V_POL    = 1;

   function automatic axis_dim_t axis_dims(input int active, input int fp,
                                           input int sync, input int bp);
      axis_dim_t d;
      d.total = active + fp + sync + bp;
      d.width = (d.total > 1) ? $clog2(d.total) : 1;
      return d;
   endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping position counter with registered sync/visible flags
// that always describe the count currently presented.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = VGA640_H_ACTIVE,
   parameter int FP     = VGA640_H_FP,
   parameter int SYNC   = VGA640_H_SYNC,
   parameter int BP     = VGA640_H_BP,
   parameter int POL    = 0,
   localparam axis_dim_t DIM = axis_dims(ACTIVE, FP, SYNC, BP),
   localparam int W = DIM.width
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         step,
   output logic [W-1:0] count,
   output logic         wrap,
   output logic         sync,
   output logic         visible
);

   // One extra bit so the sync end bound cannot overflow when BP is 0.
   localparam logic [W:0] LAST     = (W+1)'(DIM.total - 1);
   localparam logic [W:0] SYNC_BEG = (W+1)'(ACTIVE + FP);
   localparam logic [W:0] SYNC_END = (W+1)'(ACTIVE + FP + SYNC);
   localparam logic [W:0] VIS_END  = (W+1)'(ACTIVE);
   localparam logic       ASSERTED = 1'(POL);

   logic [W-1:0] count_q, count_d;
   logic         sync_q, sync_d;
   logic         visible_q, visible_d;
   logic [W:0]   count_ext;

   always_comb begin
      wrap    = step && ({1'b0, count_q} == LAST);
      count_d = count_q;
      if (step) begin
         count_d = wrap ? '0 : count_q + W'(1);
      end
      // Flags are decoded from the next count so they line up with it.
      count_ext = {1'b0, count_d};
      sync_d    = (count_ext >= SYNC_BEG && count_ext < SYNC_END) ? ASSERTED : ~ASSERTED;
      visible_d = (count_ext < VIS_END);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         sync_q    <= ~ASSERTED;
         visible_q <= 1'b1;
      end else begin
         count_q   <= count_d;
         sync_q    <= sync_d;
         visible_q <= visible_d;
      end
   end

   assign count   = count_q;
   assign sync    = sync_q;
   assign visible = visible_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider plus horizontal/vertical axis counters.
// Optional line interrupt enabled by defining VGA_TIMING_LINE_IRQ_EN.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_ACTIVE  = VGA640_H_ACTIVE,
   parameter int H_FP      = VGA640_H_FP,
   parameter int H_SYNC    = VGA640_H_SYNC,
   parameter int H_BP      = VGA640_H_BP,
   parameter int V_ACTIVE  = VGA640_V_ACTIVE,
   parameter int V_FP      = VGA640_V_FP,
   parameter int V_SYNC    = VGA640_V_SYNC,
   parameter int V_BP      = VGA640_V_BP,
   parameter int HSYNC_POL = VGA640_H_POL,
   parameter int VSYNC_POL = VGA640_V_POL,
   localparam axis_dim_t H_DIM = axis_dims(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam axis_dim_t V_DIM = axis_dims(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int X_W = H_DIM.width,
   localparam int Y_W = V_DIM.width
)(
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
`ifdef VGA_TIMING_LINE_IRQ_EN
   input  logic [Y_W-1:0] irq_line,
   output logic           line_irq,
`endif
   output logic [X_W-1:0] pixel_x,
   output logic [Y_W-1:0] pixel_y,
   output logic           pix_tick,
   output logic           hsync,
   output logic           vsync,
   output logic           active,
   output logic           line_end,
   output logic           frame_end
);

   logic h_visible, v_visible;

   generate
      if (CLK_DIV > 1) begin : g_sub
         localparam int S_W = $clog2(CLK_DIV);
         localparam logic [S_W-1:0] SUB_LAST = S_W'(CLK_DIV - 1);
         logic [S_W-1:0] sub_q, sub_d;

         always_comb begin
            sub_d = sub_q;
            if (enable) begin
               sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + S_W'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               sub_q <= '0;
            end else begin
               sub_q <= sub_d;
            end
         end

         assign pix_tick = enable && (sub_q == SUB_LAST);
      end else begin : g_nosub
         assign pix_tick = enable;
      end
   endgenerate

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL)
   ) u_h (
      .clk     (clk),
      .reset   (reset),
      .step    (pix_tick),
      .count   (pixel_x),
      .wrap    (line_end),
      .sync    (hsync),
      .visible (h_visible)
   );

   // The vertical axis advances once per completed line.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL)
   ) u_v (
      .clk     (clk),
      .reset   (reset),
      .step    (line_end),
      .count   (pixel_y),
      .wrap    (frame_end),
      .sync    (vsync),
      .visible (v_visible)
   );

   assign active = h_visible && v_visible;

`ifdef VGA_TIMING_LINE_IRQ_EN
   logic           line_irq_q, line_irq_d;
   logic [Y_W-1:0] y_next;

   // Compare against the line the counters are about to enter.
   always_comb begin
      y_next     = frame_end ? '0 : pixel_y + Y_W'(1);
      line_irq_d = line_end && (y_next == irq_line);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         line_irq_q <= 1'b0;
      end else begin
         line_irq_q <= line_irq_d;
      end
   end

   assign line_irq = line_irq_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations checked every cycle against an
// arithmetic raster model driven by the count of enabled cycles since reset.
module tb_vga_timing_gen;

   typedef struct {
      int div, ha, hfp, hs, hbp, va, vfp, vs, vbp, hpol, vpol;
   } mode_t;

   typedef struct packed {
      logic [15:0] x, y;
      logic tick, hs, vs, act, le, fe, irq;
   } obs_t;

   logic  clk = 1'b0;
   logic  rst [3];
   logic  en  [3];
   logic  irq_o [3];
   bit    irq_exp [3];
   bit    valid [3];
   longint t_m [3];
   mode_t modes [3];
   string dn [3];
   int    n_checks = 0;
   int    n_pass   = 0;

   logic [9:0] px_a, py_a;
   logic [2:0] px_b, py_b;
   logic [3:0] px_c, py_c;
   logic tick_a, hs_a, vs_a, act_a, le_a, fe_a;
   logic tick_b, hs_b, vs_b, act_b, le_b, fe_b;
   logic tick_c, hs_c, vs_c, act_c, le_c, fe_c;
   logic [9:0] irq_a;
   logic [2:0] irq_b;
   logic [3:0] irq_c;

   always #5 clk = ~clk;

   vga_timing_gen u_a (
      .clk(clk), .reset(rst[0]), .enable(en[0]),
`ifdef VGA_TIMING_LINE_IRQ_EN
      .irq_line(irq_a), .line_irq(irq_o[0]),
`endif
      .pixel_x(px_a), .pixel_y(py_a), .pix_tick(tick_a), .hsync(hs_a), .vsync(vs_a),
      .active(act_a), .line_end(le_a), .frame_end(fe_a)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HSYNC_POL(1), .VSYNC_POL(1)
   ) u_b (
      .clk(clk), .reset(rst[1]), .enable(en[1]),
`ifdef VGA_TIMING_LINE_IRQ_EN
      .irq_line(irq_b), .line_irq(irq_o[1]),
`endif
      .pixel_x(px_b), .pixel_y(py_b), .pix_tick(tick_b), .hsync(hs_b), .vsync(vs_b),
      .active(act_b), .line_end(le_b), .frame_end(fe_b)
   );

   vga_timing_gen #(
      .CLK_DIV(3), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .HSYNC_POL(0), .VSYNC_POL(1)
   ) u_c (
      .clk(clk), .reset(rst[2]), .enable(en[2]),
`ifdef VGA_TIMING_LINE_IRQ_EN
      .irq_line(irq_c), .line_irq(irq_o[2]),
`endif
      .pixel_x(px_c), .pixel_y(py_c), .pix_tick(tick_c), .hsync(hs_c), .vsync(vs_c),
      .active(act_c), .line_end(le_c), .frame_end(fe_c)
   );

   // Raster rules in closed form: position follows from enabled cycles since reset.
   function automatic obs_t model(input mode_t m, input longint t, input logic e);
      obs_t   o;
      longint ht, vt, pix, sub, x, y;
      ht  = m.ha + m.hfp + m.hs + m.hbp;
      vt  = m.va + m.vfp + m.vs + m.vbp;
      sub = t % m.div;
      pix = t / m.div;
      x   = pix % ht;
      y   = (pix / ht) % vt;
      o.x    = 16'(x);
      o.y    = 16'(y);
      o.tick = e && (sub == m.div - 1);
      o.act  = (x < m.ha) && (y < m.va);
      o.hs   = (x >= m.ha + m.hfp && x < m.ha + m.hfp + m.hs) ? (m.hpol != 0) : (m.hpol == 0);
      o.vs   = (y >= m.va + m.vfp && y < m.va + m.vfp + m.vs) ? (m.vpol != 0) : (m.vpol == 0);
      o.le   = o.tick && (x == ht - 1);
      o.fe   = o.le && (y == vt - 1);
      o.irq  = 1'b0;
      return o;
   endfunction

   task automatic chk(input string name, input longint got, input longint want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, got, want);
   endtask

   function automatic int irq_val(input int d);
      case (d)
         0: return int'(irq_a);
         1: return int'(irq_b);
         default: return int'(irq_c);
      endcase
   endfunction

   always @(posedge clk) begin : model_step
      obs_t   e;
      longint ny;
      for (int d = 0; d < 3; d++) begin
         e  = model(modes[d], t_m[d], en[d]);
         ny = e.fe ? 0 : longint'(e.y) + 1;
`ifdef VGA_TIMING_LINE_IRQ_EN
         irq_exp[d] <= !rst[d] && e.le && (ny == longint'(irq_val(d)));
`else
         irq_exp[d] <= 1'b0;
`endif
         if (rst[d]) begin
            t_m[d]   <= 0;
            valid[d] <= 1'b1;
         end else if (en[d]) begin
            t_m[d] <= t_m[d] + 1;
         end
      end
   end

   always @(negedge clk) begin : compare
      obs_t got, want;
      for (int d = 0; d < 3; d++) begin
         if (valid[d]) begin
            want     = model(modes[d], t_m[d], en[d]);
            want.irq = irq_exp[d];
            case (d)
               0: got = '{16'(px_a), 16'(py_a), tick_a, hs_a, vs_a, act_a, le_a, fe_a, 1'b0};
               1: got = '{16'(px_b), 16'(py_b), tick_b, hs_b, vs_b, act_b, le_b, fe_b, 1'b0};
               default: got = '{16'(px_c), 16'(py_c), tick_c, hs_c, vs_c, act_c, le_c, fe_c, 1'b0};
            endcase
            got.irq = (irq_o[d] === 1'b1);
            chk(dn[d], longint'(got), longint'(want));
         end
      end
   end

   initial begin
      obs_t   o;
      longint nact;
      modes[0] = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
      modes[1] = '{1, 4, 1, 2, 1, 3, 1, 1, 1, 1, 1};
      modes[2] = '{3, 10, 2, 3, 1, 6, 1, 2, 2, 0, 1};
      dn[0] = "cycle_dutA"; dn[1] = "cycle_dutB"; dn[2] = "cycle_dutC";
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; en[d] = 1'b0; irq_o[d] = 1'b0;
      end
      irq_a = 10'd100; irq_b = 3'd2; irq_c = 4'd4;

      // Hand-computed pins on the model itself.
      o = model(modes[0], 2624, 1'b1);       chk("model_hsync_656", {o.x, o.hs}, {16'd656, 1'b0});
      o = model(modes[0], 2623, 1'b1);       chk("model_hsync_655", o.hs, 1);
      o = model(modes[0], 3199, 1'b1);       chk("model_line_end", {o.tick, o.le, o.fe}, 3'b110);
      o = model(modes[0], 1680000 - 1, 1'b1); chk("model_frame_end", {o.le, o.fe}, 2'b11);
      o = model(modes[0], 490 * 3200, 1'b1); chk("model_vsync_490", {o.y, o.vs}, {16'd490, 1'b0});
      o = model(modes[0], 492 * 3200, 1'b1); chk("model_vsync_492", o.vs, 1);
      o = model(modes[1], 37, 1'b1);         chk("model_small_xy", {o.x, o.y, o.hs, o.vs}, {16'd5, 16'd4, 2'b11});
      nact = 0;
      for (longint p = 0; p < 420000; p++) begin
         o = model(modes[0], p * 4, 1'b1);
         nact += o.act;
      end
      chk("model_active_pixels", nact, 307200);

      fork
         begin : thr_a
            int first_tick, fall, rise, le1, le2;
            first_tick = -1; fall = -1; rise = -1; le1 = -1; le2 = -1;
            repeat (3) @(posedge clk);
            #1;
            chk("a_reset_xy", {px_a, py_a}, 0);
            chk("a_reset_act_hs_vs", {act_a, hs_a, vs_a}, 3'b111);
            rst[0] = 1'b0; en[0] = 1'b1;
            for (int k = 0; k < 6400; k++) begin
               @(negedge clk);
               if (tick_a && first_tick < 0) first_tick = k;
               if (!hs_a && fall < 0) fall = k;
               if (fall >= 0 && hs_a && rise < 0) rise = k;
               if (le_a) begin
                  if (le1 < 0) le1 = k;
                  else if (le2 < 0) le2 = k;
               end
            end
            chk("a_first_tick", first_tick, 3);
            chk("a_hsync_start", fall, 2624);
            chk("a_hsync_len", rise - fall, 384);
            chk("a_line_end_first", le1, 3199);
            chk("a_line_period", le2 - le1, 3200);
            @(posedge clk); #1;
            repeat (2000) begin
               en[0] = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
            end
            rst[0] = 1'b1; en[0] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("a_midline_reset", {px_a, py_a, act_a, hs_a, vs_a, tick_a}, {20'd0, 4'b1110});
            rst[0] = 1'b0; en[0] = 1'b1;
            repeat (500) @(posedge clk);
            #1;
         end

         begin : thr_b
            int nt, nhs, nvs, mx, my;
            nt = 0; nhs = 0; nvs = 0; mx = 0; my = 0;
            repeat (2) @(posedge clk);
            #1;
            rst[1] = 1'b0; en[1] = 1'b1;
            for (int k = 0; k < 96; k++) begin
               @(negedge clk);
               nt += tick_b; nhs += hs_b; nvs += vs_b;
               if (int'(px_b) > mx) mx = int'(px_b);
               if (int'(py_b) > my) my = int'(py_b);
            end
            chk("b_tick_every_cycle", nt, 96);
            chk("b_hsync_high", nhs, 24);
            chk("b_vsync_high", nvs, 16);
            chk("b_max_xy", {mx[7:0], my[7:0]}, {8'd7, 8'd5});
            @(posedge clk); #1;
            repeat (3000) begin
               en[1]  = ($urandom_range(0, 2) != 0);
               rst[1] = ($urandom_range(0, 199) == 0);
               @(posedge clk); #1;
            end
            rst[1] = 1'b0;
         end

         begin : thr_c
            int fe1, fe2, nact_c, found, npulse;
            fe1 = -1; fe2 = -1; nact_c = 0;
            repeat (2) @(posedge clk);
            #1;
            rst[2] = 1'b0; en[2] = 1'b1;
            for (int k = 0; k < 1584; k++) begin
               @(negedge clk);
               if (k < 528) nact_c += act_c;
               if (fe_c) begin
                  if (fe1 < 0) fe1 = k;
                  else if (fe2 < 0) fe2 = k;
               end
            end
            chk("c_frame_end_first", fe1, 527);
            chk("c_frame_period", fe2 - fe1, 528);
            chk("c_active_clocks", nact_c, 180);

            found = 0;
            for (int k = 0; k < 2000 && found == 0; k++) begin
               @(negedge clk);
               if (px_c == 4'd15 && py_c == 4'd10 && !tick_c) found = 1;
            end
            chk("c_reach_last_pixel", found, 1);
            @(posedge clk); #1;
            en[2] = 1'b0;
            repeat (10) begin
               @(negedge clk);
               chk("c_hold_no_strobe", {px_c, py_c, tick_c, le_c, fe_c}, {4'd15, 4'd10, 3'b000});
            end
            @(posedge clk); #1;
            en[2] = 1'b1;
            found = 0;
            for (int k = 0; k < 4 && found == 0; k++) begin
               @(negedge clk);
               if (tick_c) begin
                  found = 1;
                  chk("c_reenable_strobes", {px_c, py_c, le_c, fe_c}, {4'd15, 4'd10, 2'b11});
               end
            end
            chk("c_reenable_tick_seen", found, 1);
            @(posedge clk); #1;
            chk("c_wrap_to_origin", {px_c, py_c}, 8'd0);

            found = 0;
            for (int k = 0; k < 2000 && found == 0; k++) begin
               @(negedge clk);
               if (px_c == 4'd5 && py_c == 4'd7) found = 1;
            end
            chk("c_reach_vsync", {found[0], vs_c}, 2'b11);
            @(posedge clk); #1;
            rst[2] = 1'b1; en[2] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("c_vsync_reset", {px_c, py_c, act_c, hs_c, vs_c, tick_c, le_c, fe_c},
                {8'd0, 6'b110000});
            rst[2] = 1'b0; en[2] = 1'b1;

`ifdef VGA_TIMING_LINE_IRQ_EN
            npulse = 0;
            irq_c  = 4'd4;
            for (int k = 0; k < 1056; k++) begin
               @(negedge clk);
               if (irq_o[2]) begin
                  npulse++;
                  chk("c_irq_position", {px_c, py_c}, {4'd0, 4'd4});
               end
            end
            chk("c_irq_per_frame", npulse, 2);
            npulse = 0;
            irq_c  = 4'd13;
            for (int k = 0; k < 1056; k++) begin
               @(negedge clk);
               npulse += irq_o[2];
            end
            chk("c_irq_out_of_range", npulse, 0);
            @(posedge clk); #1;
`else
            npulse = 0;
`endif
            repeat (2000) begin
               en[2]  = ($urandom_range(0, 3) != 0);
               rst[2] = ($urandom_range(0, 299) == 0);
               irq_c  = 4'($urandom_range(0, 15));
               @(posedge clk); #1;
            end
            rst[2] = 1'b0;
         end
      join

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It divides the system clock down to a pixel rate and runs horizontal and vertical counters over a fully configurable mode (active, front porch, sync and back porch per axis). From those counters it produces sync, blanking and position outputs. It sits between the system clock domain and the pixel/framebuffer fetch logic, and drives the VGA connector's sync pins and the pixel pipeline's coordinates.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per pixel, ≥1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HSYNC_POL, 0: asserted level of hsync (0 = active-low).
- VSYNC_POL, 0: asserted level of vsync.

Ports:
- clk, input, 1: system clock; one clock domain only.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: high = run; low = freeze all state.
- pixel_x, output, X_W: horizontal count, 0..H_TOTAL-1.
- pixel_y, output, Y_W: vertical count, 0..V_TOTAL-1.
- pix_tick, output, 1: last system cycle of the current pixel.
- hsync, output, 1: horizontal sync at the HSYNC_POL level.
- vsync, output, 1: vertical sync at the VSYNC_POL level.
- active, output, 1: current pixel is visible.
- line_end, output, 1: one-cycle strobe on the last clock of a line.
- frame_end, output, 1: one-cycle strobe on the last clock of a frame.

Derived widths:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- X_W = $clog2(H_TOTAL); Y_W = $clog2(V_TOTAL). For the default mode: 800 → 10 bits, 525 → 10 bits.

## Operation
- The sub-pixel counter counts 0..CLK_DIV-1 while enable is high.
- pix_tick = enable && sub == CLK_DIV-1. When CLK_DIV = 1 there is no sub counter and pix_tick = enable.
- On pix_tick, pixel_x increments. At pixel_x == H_TOTAL-1, pixel_x wraps to 0 and pixel_y increments. At pixel_y == V_TOTAL-1 on that same wrap, pixel_y wraps to 0.
- active = (pixel_x < H_ACTIVE) && (pixel_y < V_ACTIVE).
- hsync is asserted for H_ACTIVE+H_FP ≤ pixel_x < H_ACTIVE+H_FP+H_SYNC.
- vsync is asserted for V_ACTIVE+V_FP ≤ pixel_y < V_ACTIVE+V_FP+V_SYNC. It switches with pixel_y, aligned to the line boundary.
- line_end = pix_tick && pixel_x == H_TOTAL-1.
- frame_end = line_end && pixel_y == V_TOTAL-1.
- enable low: sub, pixel_x and pixel_y hold, and hsync/vsync/active hold their values. pix_tick, line_end and frame_end are 0. No reset occurs.
- reset dominates enable, in any state including mid-line or mid-sync.

## Timing
- Reset values:
  - sub = 0, pixel_x = 0, pixel_y = 0.
  - active = 1.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - pix_tick, line_end and frame_end = 0 for the first reset-release cycle only when CLK_DIV > 1.
- hsync, vsync and active are registered and always describe the pixel_x/pixel_y currently presented. There is zero latency relative to the counters.
- pix_tick, line_end and frame_end are combinational from registered state and enable. The only combinational input path is enable to these strobes.
- Counters update on the clock edge that ends a pix_tick cycle.
- A pixel lasts CLK_DIV clocks, a line H_TOTAL·CLK_DIV clocks, and a frame V_TOTAL·H_TOTAL·CLK_DIV clocks.

## Configuration
- VGA_TIMING_LINE_IRQ_EN defined:
  - Adds input irq_line [Y_W-1:0] and output line_irq (1 bit).
  - line_irq is a registered one-clock pulse. It fires on the clock after the edge where the counters move to pixel_x = 0 and pixel_y = irq_line.
  - irq_line is sampled at that line_end.
  - Values of irq_line ≥ V_TOTAL never fire.
  - Reset value of line_irq is 0.
- VGA_TIMING_LINE_IRQ_EN undefined: the ports and logic are absent, and all other behaviour is identical.

## Structure
- Package vga_timing_pkg holds:
  - default mode constants (640x480@60: the H and V values above, HSYNC_POL/VSYNC_POL = 0);
  - a second mode constant set (800x600@72: 800/56/120/64, 600/37/6/23, positive polarity);
  - a function computing total and width from the four segment lengths.
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical):
  - parameters ACTIVE, FP, SYNC, BP, POL;
  - ports clk, reset, step, count, wrap, sync, visible.
  - The vertical instance is stepped by the horizontal wrap.

## Test plan
- Reset with the default parameters: outputs are 0/0, active = 1, hsync = vsync = 1. After release, the first pix_tick occurs on the 4th clock.
- Run a default full frame:
  - hsync is low for 384 clocks starting 2624 clocks into each line;
  - line_end period is 3200 clocks;
  - vsync is low on lines 490-491;
  - frame_end period is 1,680,000 clocks;
  - active is high for exactly 307,200 pixels.
- Small mode with CLK_DIV = 1 (H 4/1/2/1, V 3/1/1/1, POL = 1):
  - pixel_x cycles 0..7, pixel_y cycles 0..5;
  - hsync is high at x = 5..6, vsync is high at y = 4;
  - pix_tick is high every cycle.
- Drop enable for 10 clocks at pixel_x = 799, pixel_y = 524: the counters hold, with no strobes. On re-enable, the first pix_tick gives line_end = frame_end = 1, then the counters go to 0/0.
- Assert reset mid-vsync (pixel_y = 490, pixel_x = 700): the next cycle shows the full reset values, regardless of enable.
- With VGA_TIMING_LINE_IRQ_EN and irq_line = 100: one line_irq pulse per frame, on the clock after pixel_y becomes 100. With irq_line = 600: never.
